// File: rtl/operand_fetch_pkg.sv
// rtl/operand_fetch_pkg.sv - shared config, opcodes and decode helpers for operand_fetch
//
// Purpose: datapath widths, regfile enable constants, RV32I opcode constants,
//          the operand_fetch FSM state type and the small decode helpers.
// Ports:   none (package).
package operand_fetch_pkg;

  localparam int XLEN    = 32;
  localparam int RADDR_W = 5;

  localparam logic READ_ENABLE  = 1'b1;
  localparam logic WRITE_ENABLE = 1'b1;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] SYSTEM = 7'b1110011;
  localparam logic [6:0] FENCE  = 7'b0001111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    HOLD = 2'd2
  } of_state_t;

  // rs1 is read by everything except the three formats that have no rs1 field.
  function automatic logic uses_rs1(input logic [6:0] opc);
    return (opc == LUI || opc == AUIPC || opc == JAL) ? ~READ_ENABLE : READ_ENABLE;
  endfunction

  function automatic logic uses_rs2(input logic [6:0] opc);
    return (opc == OP || opc == STORE || opc == BRANCH) ? READ_ENABLE : ~READ_ENABLE;
  endfunction

  // A writeback forwards to an operand only if that port is really read and
  // the source is not x0 (x0 is hardwired zero and never forwarded).
  function automatic logic wb_hit(input logic               flag,
                                  input logic [RADDR_W-1:0] waddr,
                                  input logic [RADDR_W-1:0] rs,
                                  input logic               en);
    return (flag == WRITE_ENABLE) && (waddr == rs) && (rs != '0) && (en == READ_ENABLE);
  endfunction

endpackage

// File: rtl/operand_fetch_imm_gen.sv
// rtl/operand_fetch_imm_gen.sv - RV32I immediate extraction and illegal-opcode detect
//
// Purpose: combinational immediate generator for the operand_fetch stage.
// Ports:   inst    - 32-bit instruction word
//          imm     - sign-extended immediate (0 for R-type, SYSTEM, FENCE, illegal)
//          illegal - opcode is not in the RV32I base set
module operand_fetch_imm_gen
  import operand_fetch_pkg::*;
(
  input  logic [31:0]     inst,
  output logic [XLEN-1:0] imm,
  output logic            illegal
);

  // Size casts of signed expressions sign-extend from inst[31].
  always_comb begin
    imm     = '0;
    illegal = 1'b0;
    case (inst[6:0])
      OP_IMM, LOAD, JALR: imm = XLEN'($signed(inst[31:20]));
      STORE:              imm = XLEN'($signed({inst[31:25], inst[11:7]}));
      BRANCH:             imm = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
      LUI, AUIPC:         imm = XLEN'($signed({inst[31:12], 12'b0}));
      JAL:                imm = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
      OP, SYSTEM, FENCE:  imm = '0;
      default:            illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/operand_fetch.sv
// rtl/operand_fetch.sv - RV32I decode/operand-fetch stage with writeback bypass
//
// Purpose: accepts an instruction from fetch, issues the regfile reads on the
//          accept edge, merges the returned data with the writeback bypass and
//          presents a registered operand bundle to execute.
// Ports:   clk, rst_n (async active-low), i_flush (sync, highest priority)
//          fetch side:   i_inst_valid / o_inst_ready, i_inst, i_pc
//          regfile side: o_rf_read_flag1/2, o_rf_read_addr1/2, i_rf_read_data1/2
//          writeback:    i_wb_flag, i_wb_addr, i_wb_data
//          execute side: o_ex_valid / i_ex_ready and the o_ex_* bundle
module operand_fetch
  import operand_fetch_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_flush,
  input  logic               i_inst_valid,
  output logic               o_inst_ready,
  input  logic [31:0]        i_inst,
  input  logic [XLEN-1:0]    i_pc,
  output logic               o_rf_read_flag1,
  output logic [RADDR_W-1:0] o_rf_read_addr1,
  input  logic [XLEN-1:0]    i_rf_read_data1,
  output logic               o_rf_read_flag2,
  output logic [RADDR_W-1:0] o_rf_read_addr2,
  input  logic [XLEN-1:0]    i_rf_read_data2,
  input  logic               i_wb_flag,
  input  logic [RADDR_W-1:0] i_wb_addr,
  input  logic [XLEN-1:0]    i_wb_data,
  output logic               o_ex_valid,
  input  logic               i_ex_ready,
  output logic [XLEN-1:0]    o_ex_pc,
  output logic [XLEN-1:0]    o_ex_rs1_data,
  output logic [XLEN-1:0]    o_ex_rs2_data,
  output logic [XLEN-1:0]    o_ex_imm,
  output logic [RADDR_W-1:0] o_ex_rd,
  output logic [6:0]         o_ex_opcode,
  output logic [2:0]         o_ex_funct3,
  output logic               o_ex_funct7b5,
  output logic               o_ex_illegal
);

  of_state_t state_q, state_d;
  logic      accept;

  logic [31:0]        inst_q;
  logic [XLEN-1:0]    pc_q;
  logic               hit1_q, hit2_q;
  logic [XLEN-1:0]    byp1_q, byp2_q;
  logic [XLEN-1:0]    op1_d, op2_d;
  logic [XLEN-1:0]    imm;
  logic               illegal;

  logic [RADDR_W-1:0] rs1_in, rs2_in, rs1_q, rs2_q;
  logic               en1_in, en2_in, en1_q, en2_q;

  assign rs1_in = i_inst[19:15];
  assign rs2_in = i_inst[24:20];
  assign en1_in = uses_rs1(i_inst[6:0]);
  assign en2_in = uses_rs2(i_inst[6:0]);
  assign rs1_q  = inst_q[19:15];
  assign rs2_q  = inst_q[24:20];
  assign en1_q  = uses_rs1(inst_q[6:0]);
  assign en2_q  = uses_rs2(inst_q[6:0]);

  operand_fetch_imm_gen u_imm_gen (
    .inst    (inst_q),
    .imm     (imm),
    .illegal (illegal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Handshake, regfile request and next state. The regfile read request is
  // only live in the accept cycle so the regfile sees exactly one read per
  // instruction; rst_n gates the ready so nothing is accepted in reset.
  always_comb begin
    state_d         = state_q;
    o_inst_ready    = 1'b0;
    o_rf_read_flag1 = 1'b0;
    o_rf_read_flag2 = 1'b0;
    o_rf_read_addr1 = '0;
    o_rf_read_addr2 = '0;

    if (rst_n && !i_flush) begin
      o_inst_ready = (state_q == IDLE) || (state_q == HOLD && i_ex_ready);
    end
    accept = i_inst_valid && o_inst_ready;

    if (accept) begin
      o_rf_read_flag1 = en1_in;
      o_rf_read_flag2 = en2_in;
      o_rf_read_addr1 = rs1_in;
      o_rf_read_addr2 = rs2_in;
    end

    if (i_flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (accept) state_d = READ;
        READ:    state_d = HOLD;
        HOLD:    if (i_ex_ready) state_d = accept ? READ : IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Operand merge at the READ->HOLD edge: a writeback landing this cycle is
  // newest, then a writeback caught on the accept edge (which the regfile
  // missed), then the regfile data itself.
  always_comb begin
    op1_d = '0;
    op2_d = '0;
    if (wb_hit(i_wb_flag, i_wb_addr, rs1_q, en1_q))  op1_d = i_wb_data;
    else if (hit1_q)                                 op1_d = byp1_q;
    else if (en1_q == READ_ENABLE && rs1_q != '0)    op1_d = i_rf_read_data1;
    if (wb_hit(i_wb_flag, i_wb_addr, rs2_q, en2_q))  op2_d = i_wb_data;
    else if (hit2_q)                                 op2_d = byp2_q;
    else if (en2_q == READ_ENABLE && rs2_q != '0)    op2_d = i_rf_read_data2;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inst_q        <= '0;
      pc_q          <= '0;
      hit1_q        <= 1'b0;
      hit2_q        <= 1'b0;
      byp1_q        <= '0;
      byp2_q        <= '0;
      o_ex_valid    <= 1'b0;
      o_ex_pc       <= '0;
      o_ex_rs1_data <= '0;
      o_ex_rs2_data <= '0;
      o_ex_imm      <= '0;
      o_ex_rd       <= '0;
      o_ex_opcode   <= '0;
      o_ex_funct3   <= '0;
      o_ex_funct7b5 <= 1'b0;
      o_ex_illegal  <= 1'b0;
    end else if (i_flush) begin
      o_ex_valid <= 1'b0;
      hit1_q     <= 1'b0;
      hit2_q     <= 1'b0;
    end else begin
      if (accept) begin
        inst_q <= i_inst;
        pc_q   <= i_pc;
        hit1_q <= wb_hit(i_wb_flag, i_wb_addr, rs1_in, en1_in);
        hit2_q <= wb_hit(i_wb_flag, i_wb_addr, rs2_in, en2_in);
        byp1_q <= i_wb_data;
        byp2_q <= i_wb_data;
      end
      case (state_q)
        READ: begin
          o_ex_valid    <= 1'b1;
          o_ex_pc       <= pc_q;
          o_ex_rs1_data <= op1_d;
          o_ex_rs2_data <= op2_d;
          o_ex_imm      <= imm;
          o_ex_rd       <= inst_q[11:7];
          o_ex_opcode   <= inst_q[6:0];
          o_ex_funct3   <= inst_q[14:12];
          o_ex_funct7b5 <= inst_q[30];
          o_ex_illegal  <= illegal;
        end
        HOLD: begin
          if (i_ex_ready) begin
            o_ex_valid <= 1'b0;
          end else begin
            // Keep the held operands current with writebacks that retire
            // while execute is stalled.
            if (wb_hit(i_wb_flag, i_wb_addr, rs1_q, en1_q)) o_ex_rs1_data <= i_wb_data;
            if (wb_hit(i_wb_flag, i_wb_addr, rs2_q, en2_q)) o_ex_rs2_data <= i_wb_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// tb/tb_operand_fetch.sv - directed self-checking bench for operand_fetch
module tb_operand_fetch;

  logic        clk;
  logic        rst_n;
  logic        i_flush;
  logic        i_inst_valid;
  logic        o_inst_ready;
  logic [31:0] i_inst;
  logic [31:0] i_pc;
  logic        o_rf_read_flag1;
  logic [4:0]  o_rf_read_addr1;
  logic [31:0] i_rf_read_data1;
  logic        o_rf_read_flag2;
  logic [4:0]  o_rf_read_addr2;
  logic [31:0] i_rf_read_data2;
  logic        i_wb_flag;
  logic [4:0]  i_wb_addr;
  logic [31:0] i_wb_data;
  logic        o_ex_valid;
  logic        i_ex_ready;
  logic [31:0] o_ex_pc;
  logic [31:0] o_ex_rs1_data;
  logic [31:0] o_ex_rs2_data;
  logic [31:0] o_ex_imm;
  logic [4:0]  o_ex_rd;
  logic [6:0]  o_ex_opcode;
  logic [2:0]  o_ex_funct3;
  logic        o_ex_funct7b5;
  logic        o_ex_illegal;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] ADD_X3_X1_X2 = 32'h002081B3;
  localparam logic [31:0] ADDI_X5_M1   = 32'hFFF08293;

  operand_fetch dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_flush         (i_flush),
    .i_inst_valid    (i_inst_valid),
    .o_inst_ready    (o_inst_ready),
    .i_inst          (i_inst),
    .i_pc            (i_pc),
    .o_rf_read_flag1 (o_rf_read_flag1),
    .o_rf_read_addr1 (o_rf_read_addr1),
    .i_rf_read_data1 (i_rf_read_data1),
    .o_rf_read_flag2 (o_rf_read_flag2),
    .o_rf_read_addr2 (o_rf_read_addr2),
    .i_rf_read_data2 (i_rf_read_data2),
    .i_wb_flag       (i_wb_flag),
    .i_wb_addr       (i_wb_addr),
    .i_wb_data       (i_wb_data),
    .o_ex_valid      (o_ex_valid),
    .i_ex_ready      (i_ex_ready),
    .o_ex_pc         (o_ex_pc),
    .o_ex_rs1_data   (o_ex_rs1_data),
    .o_ex_rs2_data   (o_ex_rs2_data),
    .o_ex_imm        (o_ex_imm),
    .o_ex_rd         (o_ex_rd),
    .o_ex_opcode     (o_ex_opcode),
    .o_ex_funct3     (o_ex_funct3),
    .o_ex_funct7b5   (o_ex_funct7b5),
    .o_ex_illegal    (o_ex_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model: synchronous read returning pre-write data, zeros
  // for a disabled read, x0 never written.
  logic [31:0] rf [0:31] = '{default: 32'd0};
  always @(posedge clk) begin
    i_rf_read_data1 <= o_rf_read_flag1 ? rf[o_rf_read_addr1] : 32'd0;
    i_rf_read_data2 <= o_rf_read_flag2 ? rf[o_rf_read_addr2] : 32'd0;
    if (i_wb_flag && i_wb_addr != 5'd0) rf[i_wb_addr] <= i_wb_data;
  end

  typedef struct {
    logic [31:0] inst;
    logic [31:0] f1;
    logic [31:0] f2;
    logic [31:0] rd;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic [31:0] ill;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [31:0] inst, input logic [31:0] pc);
    i_inst_valid = 1'b1;
    i_inst       = inst;
    i_pc         = pc;
    #1;
  endtask

  task automatic wb_write(input logic [4:0] addr, input logic [31:0] data);
    i_wb_flag = 1'b1;
    i_wb_addr = addr;
    i_wb_data = data;
    tick();
    i_wb_flag = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  initial begin
    rst_n        = 1'b0;
    i_flush      = 1'b0;
    i_inst_valid = 1'b1;
    i_inst       = ADD_X3_X1_X2;
    i_pc         = 32'h0;
    i_wb_flag    = 1'b0;
    i_wb_addr    = 5'd0;
    i_wb_data    = 32'd0;
    i_ex_ready   = 1'b1;

    vecs[0] = '{ADD_X3_X1_X2, 32'd1, 32'd1, 32'd3,  32'd5, 32'd7, 32'h00000000, 32'd0};
    vecs[1] = '{ADDI_X5_M1,   32'd1, 32'd0, 32'd5,  32'd5, 32'd0, 32'hFFFFFFFF, 32'd0};
    vecs[2] = '{32'h0020A423, 32'd1, 32'd1, 32'd8,  32'd5, 32'd7, 32'h00000008, 32'd0};
    vecs[3] = '{32'hFE208EE3, 32'd1, 32'd1, 32'd29, 32'd5, 32'd7, 32'hFFFFFFFC, 32'd0};
    vecs[4] = '{32'h010000EF, 32'd0, 32'd0, 32'd1,  32'd0, 32'd0, 32'h00000010, 32'd0};
    vecs[5] = '{32'h123453B7, 32'd0, 32'd0, 32'd7,  32'd0, 32'd0, 32'h12345000, 32'd0};
    vecs[6] = '{32'h0020807F, 32'd1, 32'd0, 32'd0,  32'd5, 32'd0, 32'h00000000, 32'd1};

    repeat (2) @(posedge clk);
    #1;
    check("rst_inst_ready", 32'(o_inst_ready), 32'd0);
    check("rst_rf_flag1",   32'(o_rf_read_flag1), 32'd0);
    check("rst_rf_addr1",   32'(o_rf_read_addr1), 32'd0);
    check("rst_ex_valid",   32'(o_ex_valid), 32'd0);
    check("rst_ex_pc",      o_ex_pc, 32'd0);
    i_inst_valid = 1'b0;
    rst_n = 1'b1;
    tick();

    wb_write(5'd1, 32'd5);
    wb_write(5'd2, 32'd7);
    wb_write(5'd31, 32'h99);

    foreach (vecs[k]) begin
      present(vecs[k].inst, 32'h100 + 32'(k) * 4);
      check("acc_ready", 32'(o_inst_ready), 32'd1);
      check("acc_flag1", 32'(o_rf_read_flag1), vecs[k].f1);
      check("acc_flag2", 32'(o_rf_read_flag2), vecs[k].f2);
      check("acc_addr1", 32'(o_rf_read_addr1), 32'(vecs[k].inst[19:15]));
      if (vecs[k].f2 == 32'd1) check("acc_addr2", 32'(o_rf_read_addr2), 32'(vecs[k].inst[24:20]));
      tick();
      i_inst_valid = 1'b0;
      check("read_valid", 32'(o_ex_valid), 32'd0);
      check("read_flag1", 32'(o_rf_read_flag1), 32'd0);
      tick();
      check("ex_valid", 32'(o_ex_valid), 32'd1);
      check("ex_pc",    o_ex_pc, 32'h100 + 32'(k) * 4);
      check("ex_rs1",   o_ex_rs1_data, vecs[k].rs1);
      check("ex_rs2",   o_ex_rs2_data, vecs[k].rs2);
      check("ex_imm",   o_ex_imm, vecs[k].imm);
      check("ex_rd",    32'(o_ex_rd), vecs[k].rd);
      check("ex_opc",   32'(o_ex_opcode), 32'(vecs[k].inst[6:0]));
      check("ex_ill",   32'(o_ex_illegal), vecs[k].ill);
      tick();
      check("ex_drop",  32'(o_ex_valid), 32'd0);
    end

    // Writeback on the accept edge: regfile returns stale 5, bypass wins.
    present(ADD_X3_X1_X2, 32'h200);
    i_wb_flag = 1'b1; i_wb_addr = 5'd1; i_wb_data = 32'h1234;
    tick();
    i_inst_valid = 1'b0; i_wb_flag = 1'b0;
    tick();
    check("byp_e0_rs1", o_ex_rs1_data, 32'h1234);
    check("byp_e0_rs2", o_ex_rs2_data, 32'd7);
    tick();
    wb_write(5'd1, 32'd5);

    // Writeback during READ.
    present(ADD_X3_X1_X2, 32'h204);
    tick();
    i_inst_valid = 1'b0;
    i_wb_flag = 1'b1; i_wb_addr = 5'd1; i_wb_data = 32'h1234;
    tick();
    i_wb_flag = 1'b0;
    check("byp_rd_rs1", o_ex_rs1_data, 32'h1234);
    tick();
    wb_write(5'd1, 32'd5);

    // Stall in HOLD with a writeback to rs2, then a back-to-back accept.
    i_ex_ready = 1'b0;
    present(ADD_X3_X1_X2, 32'h208);
    tick();
    i_inst_valid = 1'b0;
    tick();
    check("hold_valid0", 32'(o_ex_valid), 32'd1);
    check("hold_rs2_0",  o_ex_rs2_data, 32'd7);
    i_wb_flag = 1'b1; i_wb_addr = 5'd2; i_wb_data = 32'hAA;
    tick();
    i_wb_flag = 1'b0;
    check("hold_valid1", 32'(o_ex_valid), 32'd1);
    check("hold_rs2_1",  o_ex_rs2_data, 32'hAA);
    check("hold_rs1_1",  o_ex_rs1_data, 32'd5);
    check("hold_pc",     o_ex_pc, 32'h208);
    tick();
    check("hold_valid3", 32'(o_ex_valid), 32'd1);
    check("hold_ready",  32'(o_inst_ready), 32'd0);
    i_ex_ready = 1'b1;
    present(ADDI_X5_M1, 32'h20C);
    check("b2b_ready", 32'(o_inst_ready), 32'd1);
    tick();
    i_inst_valid = 1'b0;
    check("b2b_drop", 32'(o_ex_valid), 32'd0);
    tick();
    check("b2b_valid", 32'(o_ex_valid), 32'd1);
    check("b2b_rs1",   o_ex_rs1_data, 32'd5);
    check("b2b_imm",   o_ex_imm, 32'hFFFFFFFF);
    check("b2b_pc",    o_ex_pc, 32'h20C);
    tick();
    check("b2b_end", 32'(o_ex_valid), 32'd0);

    // x0 source with x0 writebacks on both edges.
    present(32'h01000313, 32'h300);
    i_wb_flag = 1'b1; i_wb_addr = 5'd0; i_wb_data = 32'hFFFF;
    tick();
    i_inst_valid = 1'b0;
    tick();
    i_wb_flag = 1'b0;
    check("x0_rs1", o_ex_rs1_data, 32'd0);
    check("x0_imm", o_ex_imm, 32'h10);
    tick();

    // Flush during READ.
    present(ADD_X3_X1_X2, 32'h400);
    tick();
    i_inst_valid = 1'b0;
    i_flush = 1'b1;
    tick();
    check("flush_valid", 32'(o_ex_valid), 32'd0);
    present(ADD_X3_X1_X2, 32'h404);
    check("flush_ready", 32'(o_inst_ready), 32'd0);
    check("flush_flag1", 32'(o_rf_read_flag1), 32'd0);
    tick();
    i_inst_valid = 1'b0;
    i_flush = 1'b0;
    tick();
    check("flush_valid2", 32'(o_ex_valid), 32'd0);
    tick();
    check("flush_valid3", 32'(o_ex_valid), 32'd0);

    // Asynchronous reset while holding a bundle.
    i_ex_ready = 1'b0;
    present(ADD_X3_X1_X2, 32'h500);
    tick();
    i_inst_valid = 1'b0;
    tick();
    check("rh_valid", 32'(o_ex_valid), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("rh_rst_valid", 32'(o_ex_valid), 32'd0);
    check("rh_rst_rs1",   o_ex_rs1_data, 32'd0);
    check("rh_rst_rs2",   o_ex_rs2_data, 32'd0);
    check("rh_rst_pc",    o_ex_pc, 32'd0);
    check("rh_rst_rd",    32'(o_ex_rd), 32'd0);
    check("rh_rst_opc",   32'(o_ex_opcode), 32'd0);
    i_inst_valid = 1'b1;
    #1;
    check("rh_rst_ready", 32'(o_inst_ready), 32'd0);
    check("rh_rst_flag1", 32'(o_rf_read_flag1), 32'd0);
    i_inst_valid = 1'b0;
    #1 rst_n = 1'b1;
    i_ex_ready = 1'b1;
    tick();
    present(ADD_X3_X1_X2, 32'h504);
    tick();
    i_inst_valid = 1'b0;
    tick();
    check("post_valid", 32'(o_ex_valid), 32'd1);
    check("post_rs1",   o_ex_rs1_data, 32'd5);
    check("post_rs2",   o_ex_rs2_data, 32'hAA);
    check("post_pc",    o_ex_pc, 32'h504);
    tick();
    check("post_drop",  32'(o_ex_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
